// File: rtl/bcd_entry_to_bin.sv
// Two-digit BCD entry register with a sequential BCD-to-binary converter.
// The digits shift in from the right, so each new digit pushes the previous
// units digit into tens. On start, a reverse double-dabble runs for one
// iteration per clock over {tens, units, 7'b0}. After seven iterations the
// low seven bits hold the binary value.
module bcd_entry_to_bin #(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   digit_in,
  input  logic         digit_valid,
  input  logic         clear,
  input  logic         start,
  output logic [3:0]   tens,
  output logic [3:0]   units,
  output logic         busy,
  output logic [N-1:0] bin_out,
  output logic         bin_valid,
  output logic         digit_err
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] CONVERT = 1'b1;

  localparam logic [2:0] LAST_ITER = 3'd6;

  logic [0:0]  state;
  logic [14:0] sr;
  logic [2:0]  cnt;
  logic [14:0] sr_sh;
  logic [14:0] sr_nx;
  logic        digit_ok;

  assign sr_sh    = {1'b0, sr[14:1]};
  assign digit_ok = (digit_in <= 4'd9);

  // One reverse double-dabble step: shift right, then correct each BCD field.
  always_comb begin
    sr_nx = sr_sh;
    if (sr_sh[14:11] >= 4'd8) sr_nx[14:11] = sr_sh[14:11] - 4'd3;
    if (sr_sh[10:7]  >= 4'd8) sr_nx[10:7]  = sr_sh[10:7]  - 4'd3;
  end

  // Entry, conversion control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      tens      <= '0;
      units     <= '0;
      busy      <= 1'b0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      digit_err <= 1'b0;
    end else begin
      digit_err <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            tens      <= '0;
            units     <= '0;
            bin_valid <= 1'b0;
          end else if (start) begin
            sr        <= {tens, units, 7'b0};
            cnt       <= '0;
            busy      <= 1'b1;
            bin_valid <= 1'b0;
            state     <= CONVERT;
          end else if (digit_valid) begin
            if (digit_ok) begin
              tens      <= units;
              units     <= digit_in;
              bin_valid <= 1'b0;
            end else begin
              digit_err <= 1'b1;
            end
          end
        end
        default: begin
          // Strobes are ignored here. The held digits stay frozen for the display echo.
          sr  <= sr_nx;
          cnt <= cnt + 3'd1;
          if (cnt == LAST_ITER) begin
            bin_out   <= N'(sr_sh[6:0]);
            bin_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_entry_to_bin.sv
// Scoreboard bench for bcd_entry_to_bin. The expected binary value is pushed
// when start is driven. It is popped on each rising edge of bin_valid.
module tb_bcd_entry_to_bin;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   digit_in;
  logic         digit_valid;
  logic         clear;
  logic         start;
  logic [3:0]   tens;
  logic [3:0]   units;
  logic         busy;
  logic [N-1:0] bin_out;
  logic         bin_valid;
  logic         digit_err;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] sb[$];
  logic         bv_prev = 1'b0;

  bcd_entry_to_bin #(.N(N)) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
    .clear(clear), .start(start), .tens(tens), .units(units), .busy(busy),
    .bin_out(bin_out), .bin_valid(bin_valid), .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  // Result monitor: each new bin_valid compares bin_out with the oldest expectation.
  always @(negedge clk) begin
    if (bin_valid && !bv_prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected bin_out=%0d with empty scoreboard", bin_out);
      end else begin
        logic [N-1:0] e;
        e = sb.pop_front();
        if (bin_out !== e) begin
          errors++;
          $display("FAIL result bin_out=%0d expected=%0d", bin_out, e);
        end
      end
    end
    bv_prev = bin_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [3:0] d);
    digit_in = d; digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
  endtask

  task automatic start_conv(input int exp);
    sb.push_back(N'(exp));
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy=%b still set after %0d cycles", busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; digit_in = '0; digit_valid = 1'b0; clear = 1'b0; start = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({tens, units, busy, bin_out, bin_valid, digit_err} !== '0) begin
      errors++;
      $display("FAIL reset tens=%0d units=%0d busy=%b bin_out=%0d bin_valid=%b digit_err=%b required all zero",
               tens, units, busy, bin_out, bin_valid, digit_err);
    end
  endtask

  task automatic test_basic();
    enter(4); enter(2);
    checks++;
    if (tens !== 4'd4 || units !== 4'd2) begin
      errors++;
      $display("FAIL entry_42 tens=%0d units=%0d required 4 2", tens, units);
    end
    start_conv(42);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (busy !== 1'b1 || bin_valid !== 1'b0) begin
        errors++;
        $display("FAIL busy_window cycle %0d busy=%b bin_valid=%b required 1 0", i, busy, bin_valid);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || bin_valid !== 1'b1 || bin_out !== 8'd42) begin
      errors++;
      $display("FAIL done_42 busy=%b bin_valid=%b bin_out=%0d required 0 1 42", busy, bin_valid, bin_out);
    end
  endtask

  task automatic test_back_to_back();
    // A restart at the earliest edge after completion must be accepted.
    start_conv(42);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_e8 busy=%b required 1", busy);
    end
    wait_idle();
    enter(9); enter(9); start_conv(99); wait_idle();
    enter(0); enter(0); start_conv(0); wait_idle();
    checks++;
    if (bin_valid !== 1'b1 || bin_out !== 8'd0) begin
      errors++;
      $display("FAIL zero bin_valid=%b bin_out=%0d required 1 0", bin_valid, bin_out);
    end
  endtask

  task automatic test_shift_entry();
    enter(1); enter(2); enter(3);
    checks++;
    if (tens !== 4'd2 || units !== 4'd3 || bin_valid !== 1'b0) begin
      errors++;
      $display("FAIL shift_entry tens=%0d units=%0d bin_valid=%b required 2 3 0", tens, units, bin_valid);
    end
    start_conv(23); wait_idle();
  endtask

  task automatic test_digit_err();
    enter(4'd12);
    checks++;
    if (digit_err !== 1'b1 || tens !== 4'd2 || units !== 4'd3) begin
      errors++;
      $display("FAIL digit_err_pulse err=%b tens=%0d units=%0d required 1 2 3", digit_err, tens, units);
    end
    step();
    checks++;
    if (digit_err !== 1'b0 || bin_valid !== 1'b1) begin
      errors++;
      $display("FAIL digit_err_width err=%b bin_valid=%b required 0 1", digit_err, bin_valid);
    end
  endtask

  task automatic test_priority();
    enter(3); enter(7);
    digit_in = 4'd5; digit_valid = 1'b1;
    start_conv(37);
    digit_valid = 1'b0;
    wait_idle();
    checks++;
    if (tens !== 4'd3 || units !== 4'd7) begin
      errors++;
      $display("FAIL start_over_digit tens=%0d units=%0d required 3 7", tens, units);
    end
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    checks++;
    if (tens !== 4'd0 || units !== 4'd0 || busy !== 1'b0 || bin_valid !== 1'b0 || bin_out !== 8'd37) begin
      errors++;
      $display("FAIL clear_over_start tens=%0d units=%0d busy=%b bin_valid=%b bin_out=%0d required 0 0 0 0 37",
               tens, units, busy, bin_valid, bin_out);
    end
  endtask

  task automatic test_mid_reset();
    enter(5); enter(6);
    start_conv(56);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb.pop_back());
    checks++;
    if ({tens, units, busy, bin_out, bin_valid} !== '0) begin
      errors++;
      $display("FAIL mid_reset tens=%0d units=%0d busy=%b bin_out=%0d bin_valid=%b required all zero",
               tens, units, busy, bin_out, bin_valid);
    end
  endtask

  task automatic test_convert_ignore();
    enter(1); enter(8);
    start_conv(18);
    step();
    digit_in = 4'd7; digit_valid = 1'b1;
    step();
    digit_in = 4'd11;
    step();
    digit_valid = 1'b0;
    checks++;
    if (digit_err !== 1'b0 || tens !== 4'd1 || units !== 4'd8 || busy !== 1'b1) begin
      errors++;
      $display("FAIL convert_ignore err=%b tens=%0d units=%0d busy=%b required 0 1 8 1", digit_err, tens, units, busy);
    end
    wait_idle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int t, u;
      t = $urandom_range(9);
      u = $urandom_range(9);
      enter(4'(t)); enter(4'(u));
      start_conv(t * 10 + u);
      wait_idle();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_shift_entry();
    test_digit_err();
    test_priority();
    test_mid_reset();
    test_convert_ignore();
    test_random();
    step(); step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_entry_to_bin.md
Name: bcd_entry_to_bin

Overview:
Decimal entry block: accepts one-digit BCD key/switch entries, holds a 2-digit decimal number (tens, units) and converts it to binary on request.
- Conversion is a sequential reverse double-dabble, one iteration per clock.
- The held digits are exported for echo on decoder_7_seg displays.
- The binary result feeds downstream arithmetic such as nbit_adder.

Parameters:
N, 7, width of bin_out; must be >= 7; result is zero-extended to N bits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
digit_in  input  4  BCD digit to enter; values 10..15 are invalid.
digit_valid  input  1  one-cycle strobe: enter digit_in.
clear  input  1  one-cycle strobe: zero the digits and drop bin_valid.
start  input  1  one-cycle strobe: convert the held digits.
tens  output  4  held tens digit (registered).
units  output  4  held units digit (registered).
busy  output  1  high while a conversion is in progress.
bin_out  output  N  binary value of the last completed conversion.
bin_valid  output  1  level: bin_out matches the held digits.
digit_err  output  1  one-cycle pulse: an invalid digit was strobed.

Behaviour:
- Reset (rst sampled high): tens=0, units=0, bin_out=0, bin_valid=0, busy=0, digit_err=0, state=IDLE. Applies from any state, including mid-conversion; the partial result is discarded.
- States: IDLE, CONVERT.
- IDLE, inputs sampled each edge with priority clear > start > digit_valid. Only the highest-priority strobe acts; the others are discarded.
  - clear: tens<=0, units<=0, bin_valid<=0.
  - start: load the 15-bit shift register {tens, units, 7'b0}; iteration counter<=0; busy<=1; bin_valid<=0; go to CONVERT.
  - digit_valid with digit_in<=9: tens<=units, units<=digit_in, bin_valid<=0. The old tens digit is lost (entering 1,2,3 leaves 2,3).
  - digit_valid with digit_in>9: tens and units unchanged; digit_err=1 for exactly the next cycle.
- CONVERT, one iteration per edge, 7 iterations:
  - Shift the whole register right by 1.
  - Then for each 4-bit BCD field (bits 14:11, 10:7): if the field is >= 8, subtract 3.
  - The counter increments each iteration. On the 7th iteration the next state is IDLE.
  - At that same edge: bin_out <= low 7 bits of the post-shift register, zero-extended to N; bin_valid<=1; busy<=0.
- Latency:
  - start sampled at edge E0; iterations at E1..E7; bin_out/bin_valid update at E7.
  - busy is high for exactly 7 cycles after E0.
  - A new start is accepted at E8 at the earliest.
- Strobes during CONVERT (digit_valid, start, clear) are ignored and not queued. digit_err does not pulse during CONVERT.
- Held tens/units do not change during CONVERT, so display echo is stable.
- bin_valid stays high until the next clear, start, valid digit entry or reset; bin_out holds its last value after clear.
- Range: 0..99. The result always fits in 7 bits; no overflow is possible.

Test Plan:
- Reset, enter 4 then 2, pulse start -> tens=4, units=2; busy high 7 cycles; bin_out=42 (0101010), bin_valid=1 at E7.
- Enter 9,9, start -> bin_out=99 (1100011); enter 0,0, start -> bin_out=0, bin_valid=1.
- Enter 1,2,3 -> tens=2, units=3; start -> bin_out=23.
- digit_in=12 with digit_valid -> digit_err one-cycle pulse; tens/units unchanged.
- Same cycle in IDLE:
  - start+digit_valid(5) with held 3,7 -> converts 37; digit dropped.
  - clear+start -> digits become 0, no conversion, busy stays 0.
- Mid-conversion events:
  - Assert rst at E3 -> next cycle busy=0, bin_valid=0, bin_out=0, tens=units=0.
  - digit_valid at E2 (no reset) -> ignored; result unchanged.
